// File: rtl/wt_dcache_mem_bridge.sv
// Bridge between the write-through L1 dcache request/return streams and a simple burst bus.
// Optional feature: define WT_DCACHE_BRIDGE_AMO_EN to issue atomics on the bus.

package wt_dcache_bridge_pkg;
  localparam int unsigned PLEN              = 56;
  localparam int unsigned XLEN              = 64;
  localparam int unsigned DCACHE_LINE_WIDTH = 128;
  localparam int unsigned CACHE_ID_WIDTH    = 2;

  typedef enum logic [1:0] {
    DCACHE_LOAD_REQ, DCACHE_STORE_REQ, DCACHE_ATOMIC_REQ, DCACHE_INT_REQ
  } dcache_out_t;

  typedef enum logic [1:0] {
    DCACHE_LOAD_ACK, DCACHE_STORE_ACK, DCACHE_INV_REQ, DCACHE_ATOMIC_ACK
  } dcache_in_t;

  typedef enum logic [3:0] {
    AMO_NONE = 4'h0, AMO_LR, AMO_SC, AMO_SWAP, AMO_ADD, AMO_AND, AMO_OR, AMO_XOR,
    AMO_MAX, AMO_MAXU, AMO_MIN, AMO_MINU, AMO_CAS1, AMO_CAS2
  } amo_t;

  typedef struct packed {
    dcache_out_t               rtype;
    logic [2:0]                size;
    logic [PLEN-1:0]           paddr;
    logic [XLEN-1:0]           data;
    logic                      nc;
    logic [CACHE_ID_WIDTH-1:0] tid;
    amo_t                      amo_op;
  } dcache_req_t;

  typedef struct packed {
    dcache_in_t                   rtype;
    logic [DCACHE_LINE_WIDTH-1:0] data;
    logic [CACHE_ID_WIDTH-1:0]    tid;
  } dcache_rtrn_t;
endpackage

module wt_dcache_mem_bridge
  import wt_dcache_bridge_pkg::*;
#(
  parameter int unsigned ReqFifoDepth = 2,
  parameter int unsigned BeatWidth    = 64
) (
  input  logic                      clk_i,
  input  logic                      rst_ni,
  input  logic                      mem_data_req_i,
  output logic                      mem_data_ack_o,
  input  dcache_req_t               mem_data_i,
  output logic                      mem_rtrn_vld_o,
  output dcache_rtrn_t              mem_rtrn_o,
  output logic                      bus_req_valid_o,
  input  logic                      bus_req_ready_i,
  output logic                      bus_req_we_o,
  output logic [PLEN-1:0]           bus_req_addr_o,
  output logic [7:0]                bus_req_len_o,
  output logic [BeatWidth-1:0]      bus_req_wdata_o,
  output logic [BeatWidth/8-1:0]    bus_req_be_o,
  output logic [CACHE_ID_WIDTH-1:0] bus_req_id_o,
  output logic [3:0]                bus_req_amo_o,
  input  logic                      bus_rsp_valid_i,
  input  logic [CACHE_ID_WIDTH-1:0] bus_rsp_id_i,
  input  logic [BeatWidth-1:0]      bus_rsp_data_i,
  input  logic                      bus_rsp_last_i,
  output logic                      protocol_err_o
);

  localparam int unsigned NumBeats = DCACHE_LINE_WIDTH / BeatWidth;
  localparam int unsigned BeBytes  = BeatWidth / 8;
  localparam int unsigned BeatOffW = $clog2(BeBytes);
  localparam int unsigned LineOffW = $clog2(DCACHE_LINE_WIDTH / 8);
  localparam int unsigned PtrW     = (ReqFifoDepth > 1) ? $clog2(ReqFifoDepth) : 1;
  localparam int unsigned CntW     = $clog2(ReqFifoDepth + 1);
  localparam int unsigned NumTids  = 2 ** CACHE_ID_WIDTH;

  typedef enum logic [1:0] {TXN_LINE, TXN_NC, TXN_STORE, TXN_AMO} txn_t;

  // Request FIFO
  dcache_req_t     r_fifo [ReqFifoDepth];
  logic [PtrW-1:0] r_wptr, r_rptr;
  logic [CntW-1:0] r_count;
  dcache_req_t     w_head;
  logic            w_full, w_empty, w_push, w_pop;

  // Outstanding table and response tracking
  logic [NumTids-1:0]        r_busy;
  txn_t                      r_type [NumTids];
  logic [7:0]                r_len  [NumTids];
  logic [7:0]                r_beat_cnt;
  logic                      r_burst_act;
  logic [CACHE_ID_WIDTH-1:0] r_burst_id;
  logic [DCACHE_LINE_WIDTH-1:0] r_line;
  logic                      r_rtrn_vld;
  dcache_rtrn_t              r_rtrn;
  logic                      r_protocol_err;

  logic                 w_bus_cand, w_issue, w_bus_pop, w_amo_local;
  txn_t                 w_txn;
  logic                 w_we;
  logic [7:0]           w_len;
  logic [PLEN-1:0]      w_addr;
  logic [BeBytes-1:0]   w_be, w_lane_be;
  logic [BeatWidth-1:0] w_wdata, w_lane_data;
  logic [3:0]           w_amo;
  logic [BeatOffW-1:0]  w_off;

  logic w_rsp_exp_last, w_rsp_err, w_rsp_ok, w_rsp_done;
  logic [DCACHE_LINE_WIDTH-1:0] w_line;
  dcache_rtrn_t w_rtrn;

  assign w_full         = (r_count == CntW'(ReqFifoDepth));
  assign w_empty        = (r_count == '0);
  assign mem_data_ack_o = !w_full;
  assign w_push         = mem_data_req_i && !w_full;
  assign w_head         = r_fifo[r_rptr];

`ifdef WT_DCACHE_BRIDGE_AMO_EN
  assign w_bus_cand  = !w_empty;
  assign w_amo_local = 1'b0;
`else
  logic w_unused_amo;
  assign w_unused_amo = ^w_head.amo_op;
  assign w_bus_cand   = !w_empty && (w_head.rtype != DCACHE_ATOMIC_REQ);
  // A local atomic ack yields to a bus return finishing in the same cycle.
  assign w_amo_local  = !w_empty && (w_head.rtype == DCACHE_ATOMIC_REQ) && !w_rsp_done;
`endif

  // Stall on the registered busy bit, so a tid freed this cycle issues next cycle.
  assign w_issue   = w_bus_cand && !r_busy[w_head.tid];
  assign w_bus_pop = w_issue && bus_req_ready_i;
  assign w_pop     = w_bus_pop || w_amo_local;

  assign w_off       = w_head.paddr[BeatOffW-1:0];
  assign w_lane_data = BeatWidth'(w_head.data) << (int'(w_off) * 8);

  always_comb begin
    for (int b = 0; b < BeBytes; b++) begin
      w_lane_be[b] = (b >= int'(w_off)) && (b < int'(w_off) + (1 << w_head.size));
    end
  end

  always_comb begin
    // NOTE: every combinational output gets a default first so no latch is inferred.
    w_txn   = TXN_NC;
    w_we    = 1'b0;
    w_len   = '0;
    w_addr  = {w_head.paddr[PLEN-1:BeatOffW], {BeatOffW{1'b0}}};
    w_be    = '0;
    w_wdata = '0;
    w_amo   = '0;
    if (w_head.rtype == DCACHE_STORE_REQ) begin
      w_txn   = TXN_STORE;
      w_we    = 1'b1;
      w_be    = w_lane_be;
      w_wdata = w_lane_data;
    end
`ifdef WT_DCACHE_BRIDGE_AMO_EN
    else if (w_head.rtype == DCACHE_ATOMIC_REQ) begin
      w_txn   = TXN_AMO;
      w_we    = 1'b1;
      w_be    = w_lane_be;
      w_wdata = w_lane_data;
      w_amo   = w_head.amo_op;
    end
`endif
    else if (!w_head.nc) begin
      w_txn  = TXN_LINE;
      w_len  = 8'(NumBeats - 1);
      w_addr = {w_head.paddr[PLEN-1:LineOffW], {LineOffW{1'b0}}};
    end
  end

  assign bus_req_valid_o = w_issue;
  assign bus_req_we_o    = w_issue && w_we;
  assign bus_req_addr_o  = w_issue ? w_addr  : '0;
  assign bus_req_len_o   = w_issue ? w_len   : '0;
  assign bus_req_wdata_o = w_issue ? w_wdata : '0;
  assign bus_req_be_o    = w_issue ? w_be    : '0;
  assign bus_req_id_o    = w_issue ? w_head.tid : '0;
`ifdef WT_DCACHE_BRIDGE_AMO_EN
  assign bus_req_amo_o   = w_issue ? w_amo : '0;
`else
  assign bus_req_amo_o   = '0;
`endif

  // Response checking: idle tid, id switching mid-burst, or last flag out of step with the count.
  assign w_rsp_exp_last = (r_beat_cnt == r_len[bus_rsp_id_i]);
  assign w_rsp_err  = bus_rsp_valid_i && (!r_busy[bus_rsp_id_i] ||
                      (r_burst_act && (bus_rsp_id_i != r_burst_id)) ||
                      (bus_rsp_last_i != w_rsp_exp_last));
  assign w_rsp_ok   = bus_rsp_valid_i && !w_rsp_err;
  assign w_rsp_done = w_rsp_ok && w_rsp_exp_last;

  always_comb begin
    w_line = r_line;
    for (int k = 0; k < NumBeats; k++) begin
      if (r_beat_cnt == 8'(k)) w_line[k*BeatWidth +: BeatWidth] = bus_rsp_data_i;
    end
  end

  always_comb begin
    w_rtrn.tid = bus_rsp_id_i;
    case (r_type[bus_rsp_id_i])
      TXN_LINE: begin
        w_rtrn.rtype = DCACHE_LOAD_ACK;
        w_rtrn.data  = w_line;
      end
      TXN_NC: begin
        w_rtrn.rtype = DCACHE_LOAD_ACK;
        w_rtrn.data  = {NumBeats{bus_rsp_data_i}};
      end
      TXN_AMO: begin
        w_rtrn.rtype = DCACHE_ATOMIC_ACK;
        w_rtrn.data  = DCACHE_LINE_WIDTH'(bus_rsp_data_i);
      end
      default: begin
        w_rtrn.rtype = DCACHE_STORE_ACK;
        w_rtrn.data  = '0;
      end
    endcase
  end

  // NOTE: FIFO storage is not reset; pointers and count alone define which entries are valid.
  always_ff @(posedge clk_i) begin
    if (w_push) r_fifo[r_wptr] <= mem_data_i;
  end

  // NOTE: all sequential state uses non-blocking assignments so every read sees pre-edge values.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_wptr         <= '0;
      r_rptr         <= '0;
      r_count        <= '0;
      r_busy         <= '0;
      r_beat_cnt     <= '0;
      r_burst_act    <= 1'b0;
      r_burst_id     <= '0;
      r_line         <= '0;
      r_rtrn_vld     <= 1'b0;
      r_rtrn         <= '0;
      r_protocol_err <= 1'b0;
      for (int t = 0; t < NumTids; t++) begin
        r_type[t] <= TXN_LINE;
        r_len[t]  <= '0;
      end
    end else begin
      r_rtrn_vld <= 1'b0;

      if (w_push) r_wptr <= (r_wptr == PtrW'(ReqFifoDepth - 1)) ? '0 : r_wptr + 1'b1;
      if (w_pop)  r_rptr <= (r_rptr == PtrW'(ReqFifoDepth - 1)) ? '0 : r_rptr + 1'b1;
      if (w_push && !w_pop)      r_count <= r_count + 1'b1;
      else if (!w_push && w_pop) r_count <= r_count - 1'b1;

      if (w_bus_pop) begin
        r_busy[w_head.tid] <= 1'b1;
        r_type[w_head.tid] <= w_txn;
        r_len[w_head.tid]  <= w_len;
      end

      if (w_rsp_done) begin
        r_rtrn_vld           <= 1'b1;
        r_rtrn               <= w_rtrn;
        r_busy[bus_rsp_id_i] <= 1'b0;
        r_beat_cnt           <= '0;
        r_burst_act          <= 1'b0;
      end else if (w_rsp_ok) begin
        r_line      <= w_line;
        r_beat_cnt  <= r_beat_cnt + 8'd1;
        r_burst_act <= 1'b1;
        r_burst_id  <= bus_rsp_id_i;
      end

      if (w_rsp_err) r_protocol_err <= 1'b1;

      if (w_amo_local) begin
        r_rtrn_vld     <= 1'b1;
        r_rtrn.rtype   <= DCACHE_ATOMIC_ACK;
        r_rtrn.data    <= '0;
        r_rtrn.tid     <= w_head.tid;
        r_protocol_err <= 1'b1;
      end
    end
  end

  assign mem_rtrn_vld_o = r_rtrn_vld;
  assign mem_rtrn_o     = r_rtrn;
  assign protocol_err_o = r_protocol_err;

endmodule

// File: tb/tb_wt_dcache_mem_bridge.sv
// Directed bench for wt_dcache_mem_bridge: refill, store, tid stall, backpressure, errors, reset, AMO.
module tb_wt_dcache_mem_bridge;
  import wt_dcache_bridge_pkg::*;

  logic         clk_i = 1'b0;
  logic         rst_ni;
  logic         mem_data_req_i;
  logic         mem_data_ack_o;
  dcache_req_t  req;
  logic         mem_rtrn_vld_o;
  dcache_rtrn_t mem_rtrn_o;
  logic         bus_req_valid_o;
  logic         bus_req_ready_i;
  logic         bus_req_we_o;
  logic [55:0]  bus_req_addr_o;
  logic [7:0]   bus_req_len_o;
  logic [63:0]  bus_req_wdata_o;
  logic [7:0]   bus_req_be_o;
  logic [1:0]   bus_req_id_o;
  logic [3:0]   bus_req_amo_o;
  logic         bus_rsp_valid_i;
  logic [1:0]   bus_rsp_id_i;
  logic [63:0]  bus_rsp_data_i;
  logic         bus_rsp_last_i;
  logic         protocol_err_o;

  int total = 0;
  int bad   = 0;

  wt_dcache_mem_bridge #(.ReqFifoDepth(2), .BeatWidth(64)) dut (
    .clk_i          (clk_i),
    .rst_ni         (rst_ni),
    .mem_data_req_i (mem_data_req_i),
    .mem_data_ack_o (mem_data_ack_o),
    .mem_data_i     (req),
    .mem_rtrn_vld_o (mem_rtrn_vld_o),
    .mem_rtrn_o     (mem_rtrn_o),
    .bus_req_valid_o(bus_req_valid_o),
    .bus_req_ready_i(bus_req_ready_i),
    .bus_req_we_o   (bus_req_we_o),
    .bus_req_addr_o (bus_req_addr_o),
    .bus_req_len_o  (bus_req_len_o),
    .bus_req_wdata_o(bus_req_wdata_o),
    .bus_req_be_o   (bus_req_be_o),
    .bus_req_id_o   (bus_req_id_o),
    .bus_req_amo_o  (bus_req_amo_o),
    .bus_rsp_valid_i(bus_rsp_valid_i),
    .bus_rsp_id_i   (bus_rsp_id_i),
    .bus_rsp_data_i (bus_rsp_data_i),
    .bus_rsp_last_i (bus_rsp_last_i),
    .protocol_err_o (protocol_err_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic load_req(input dcache_out_t rt, input logic [2:0] sz, input logic [55:0] pa,
                          input logic [63:0] d, input logic nc, input logic [1:0] tid,
                          input amo_t op);
    req.rtype  = rt;
    req.size   = sz;
    req.paddr  = pa;
    req.data   = d;
    req.nc     = nc;
    req.tid    = tid;
    req.amo_op = op;
    mem_data_req_i = 1'b1;
  endtask

  task automatic send(input dcache_out_t rt, input logic [2:0] sz, input logic [55:0] pa,
                      input logic [63:0] d, input logic nc, input logic [1:0] tid,
                      input amo_t op);
    load_req(rt, sz, pa, d, nc, tid, op);
    tick();
    mem_data_req_i = 1'b0;
  endtask

  task automatic beat(input logic [1:0] id, input logic [63:0] d, input logic last);
    bus_rsp_valid_i = 1'b1;
    bus_rsp_id_i    = id;
    bus_rsp_data_i  = d;
    bus_rsp_last_i  = last;
    tick();
    bus_rsp_valid_i = 1'b0;
    bus_rsp_last_i  = 1'b0;
  endtask

  initial begin
    rst_ni          = 1'b0;
    mem_data_req_i  = 1'b0;
    req             = '0;
    bus_req_ready_i = 1'b0;
    bus_rsp_valid_i = 1'b0;
    bus_rsp_id_i    = '0;
    bus_rsp_data_i  = '0;
    bus_rsp_last_i  = 1'b0;

    #12;
    check("rst_ack",   mem_data_ack_o, 1'b1);
    check("rst_vld",   mem_rtrn_vld_o, 1'b0);
    check("rst_breq",  bus_req_valid_o, 1'b0);
    check("rst_err",   protocol_err_o, 1'b0);
    check("rst_rtrn",  mem_rtrn_o, '0);
    tick();
    rst_ni = 1'b1;
    tick();

    // Line refill
    send(DCACHE_LOAD_REQ, 3'd3, 56'h8000_0048, 64'h0, 1'b0, 2'd1, AMO_NONE);
    check("ref_valid", bus_req_valid_o, 1'b1);
    check("ref_addr",  bus_req_addr_o, 56'h8000_0040);
    check("ref_len",   bus_req_len_o, 8'd1);
    check("ref_we",    bus_req_we_o, 1'b0);
    check("ref_id",    bus_req_id_o, 2'd1);
    bus_req_ready_i = 1'b1;
    tick();
    bus_req_ready_i = 1'b0;
    check("ref_idle",  bus_req_valid_o, 1'b0);
    beat(2'd1, 64'h1111_1111_1111_1111, 1'b0);
    check("ref_novld", mem_rtrn_vld_o, 1'b0);
    beat(2'd1, 64'h2222_2222_2222_2222, 1'b1);
    check("ref_vld",   mem_rtrn_vld_o, 1'b1);
    check("ref_rtype", mem_rtrn_o.rtype, DCACHE_LOAD_ACK);
    check("ref_data",  mem_rtrn_o.data, 128'h2222_2222_2222_2222_1111_1111_1111_1111);
    check("ref_tid",   mem_rtrn_o.tid, 2'd1);
    tick();
    check("ref_1cyc",  mem_rtrn_vld_o, 1'b0);

    // Byte store
    send(DCACHE_STORE_REQ, 3'd0, 56'h1003, 64'hAB, 1'b1, 2'd2, AMO_NONE);
    check("st_we",     bus_req_we_o, 1'b1);
    check("st_addr",   bus_req_addr_o, 56'h1000);
    check("st_be",     bus_req_be_o, 8'h08);
    check("st_wdata",  bus_req_wdata_o, 64'h0000_0000_AB00_0000);
    check("st_len",    bus_req_len_o, 8'd0);
    bus_req_ready_i = 1'b1;
    tick();
    bus_req_ready_i = 1'b0;
    beat(2'd2, 64'h0, 1'b1);
    check("st_vld",    mem_rtrn_vld_o, 1'b1);
    check("st_rtype",  mem_rtrn_o.rtype, DCACHE_STORE_ACK);
    check("st_data",   mem_rtrn_o.data, 128'h0);
    check("st_tid",    mem_rtrn_o.tid, 2'd2);

    // Tid collision, FIFO full
    bus_req_ready_i = 1'b1;
    send(DCACHE_LOAD_REQ, 3'd3, 56'h100, 64'h0, 1'b1, 2'd1, AMO_NONE);
    send(DCACHE_LOAD_REQ, 3'd3, 56'h200, 64'h0, 1'b1, 2'd1, AMO_NONE);
    check("col_stall", bus_req_valid_o, 1'b0);
    send(DCACHE_LOAD_REQ, 3'd3, 56'h300, 64'h0, 1'b1, 2'd3, AMO_NONE);
    check("col_full",  mem_data_ack_o, 1'b0);
    check("col_noreo", bus_req_valid_o, 1'b0);
    bus_rsp_valid_i = 1'b1;
    bus_rsp_id_i    = 2'd1;
    bus_rsp_data_i  = 64'h5A;
    bus_rsp_last_i  = 1'b1;
    #1;
    check("col_M",     bus_req_valid_o, 1'b0);
    tick();
    bus_rsp_valid_i = 1'b0;
    bus_rsp_last_i  = 1'b0;
    check("col_rvld",  mem_rtrn_vld_o, 1'b1);
    check("col_rdata", mem_rtrn_o.data, {2{64'h5A}});
    check("col_M1",    bus_req_valid_o, 1'b1);
    check("col_addr",  bus_req_addr_o, 56'h200);
    tick();
    bus_req_ready_i = 1'b0;

    // Backpressure on tid 3 request
    for (int i = 0; i < 5; i++) begin
      check("bp_valid", bus_req_valid_o, 1'b1);
      check("bp_addr",  bus_req_addr_o, 56'h300);
      check("bp_id",    bus_req_id_o, 2'd3);
      tick();
    end
    bus_req_ready_i = 1'b1;
    tick();
    bus_req_ready_i = 1'b0;
    check("bp_empty",  bus_req_valid_o, 1'b0);
    beat(2'd1, 64'h77, 1'b1);
    check("bp_rtidB",  mem_rtrn_o.tid, 2'd1);
    check("bp_rdatB",  mem_rtrn_o.data, {2{64'h77}});
    beat(2'd3, 64'h99, 1'b1);
    check("bp_rtidC",  mem_rtrn_o.tid, 2'd3);
    check("bp_noerr",  protocol_err_o, 1'b0);

    // Protocol error on idle tid
    beat(2'd3, 64'h0, 1'b1);
    check("pe_err",    protocol_err_o, 1'b1);
    check("pe_novld",  mem_rtrn_vld_o, 1'b0);
    tick();
    check("pe_sticky", protocol_err_o, 1'b1);

    // Reset mid-burst, then a clean refill
    send(DCACHE_LOAD_REQ, 3'd3, 56'h40, 64'h0, 1'b0, 2'd0, AMO_NONE);
    bus_req_ready_i = 1'b1;
    tick();
    bus_req_ready_i = 1'b0;
    beat(2'd0, 64'hDEAD, 1'b0);
    #2;
    rst_ni = 1'b0;
    #1;
    check("mr_err",    protocol_err_o, 1'b0);
    check("mr_vld",    mem_rtrn_vld_o, 1'b0);
    check("mr_breq",   bus_req_valid_o, 1'b0);
    check("mr_ack",    mem_data_ack_o, 1'b1);
    tick();
    rst_ni = 1'b1;
    send(DCACHE_LOAD_REQ, 3'd3, 56'h88, 64'h0, 1'b0, 2'd0, AMO_NONE);
    check("mr_addr",   bus_req_addr_o, 56'h80);
    bus_req_ready_i = 1'b1;
    tick();
    bus_req_ready_i = 1'b0;
    beat(2'd0, 64'hAAAA_AAAA_AAAA_AAAA, 1'b0);
    beat(2'd0, 64'hBBBB_BBBB_BBBB_BBBB, 1'b1);
    check("mr_rvld",   mem_rtrn_vld_o, 1'b1);
    check("mr_rdata",  mem_rtrn_o.data, 128'hBBBB_BBBB_BBBB_BBBB_AAAA_AAAA_AAAA_AAAA);
    check("mr_noerr",  protocol_err_o, 1'b0);

    // Atomic add
    send(DCACHE_ATOMIC_REQ, 3'd3, 56'h2000, 64'h3, 1'b1, 2'd1, AMO_ADD);
`ifdef WT_DCACHE_BRIDGE_AMO_EN
    check("amo_valid", bus_req_valid_o, 1'b1);
    check("amo_op",    bus_req_amo_o, 4'd4);
    check("amo_we",    bus_req_we_o, 1'b1);
    check("amo_be",    bus_req_be_o, 8'hFF);
    bus_req_ready_i = 1'b1;
    tick();
    bus_req_ready_i = 1'b0;
    beat(2'd1, 64'h5, 1'b1);
    check("amo_rvld",  mem_rtrn_vld_o, 1'b1);
    check("amo_rtype", mem_rtrn_o.rtype, DCACHE_ATOMIC_ACK);
    check("amo_rdata", mem_rtrn_o.data, 128'h5);
    check("amo_noerr", protocol_err_o, 1'b0);
`else
    check("amo_nobus", bus_req_valid_o, 1'b0);
    check("amo_op0",   bus_req_amo_o, 4'd0);
    tick();
    check("amo_rvld",  mem_rtrn_vld_o, 1'b1);
    check("amo_rtype", mem_rtrn_o.rtype, DCACHE_ATOMIC_ACK);
    check("amo_rdata", mem_rtrn_o.data, 128'h0);
    check("amo_rtid",  mem_rtrn_o.tid, 2'd1);
    check("amo_err",   protocol_err_o, 1'b1);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
